// File: rtl/fetch_pc_unit.sv
// Program counter and IF/ID pipeline latch: fetch-address check, stall/flush
// handling and a running count of instructions latched for decode.
module fetch_pc_unit #(
    parameter logic [31:0] TEXT_START  = 32'h0000_3000,
    parameter logic [31:0] TEXT_END    = 32'h0000_6FFF,
    parameter logic [31:0] KTEXT_START = 32'h0000_4180,
    parameter logic [31:0] KTEXT_END   = 32'h0000_4FFF,
    parameter logic [4:0]  EXC_ADEL    = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_in_id,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_bd,
    output logic [4:0]  id_exc,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } ifid_t;

    logic [31:0] pc_q;
    logic [31:0] count_q;
    ifid_t       ifid_q;
    ifid_t       fetch_d;
    ifid_t       bubble_d;

    logic misaligned;
    logic in_user;
    logic in_kernel;
    logic bad_addr;

    // Fetch check is purely on the registered pc, so it is stable all cycle.
    always_comb begin
        misaligned = (pc_q[1:0] != 2'b00);
        in_user    = (pc_q >= TEXT_START)  && (pc_q <= TEXT_END);
        in_kernel  = (pc_q >= KTEXT_START) && (pc_q <= KTEXT_END);
        bad_addr   = misaligned || !(in_user || in_kernel);
    end

    always_comb begin
        fetch_d.instr = bad_addr ? 32'h0000_0000 : im_rdata;
        fetch_d.pc    = pc_q;
        fetch_d.bd    = branch_in_id;
        fetch_d.exc   = bad_addr ? EXC_ADEL : 5'd0;
        fetch_d.valid = 1'b1;
    end

    // A flushed slot keeps the redirect target as its PC for CP0 reporting.
    always_comb begin
        bubble_d.instr = 32'h0000_0000;
        bubble_d.pc    = npc;
        bubble_d.bd    = 1'b0;
        bubble_d.exc   = 5'd0;
        bubble_d.valid = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= TEXT_START;
            ifid_q  <= '0;
            count_q <= 32'd0;
        end else if (flush) begin
            pc_q   <= npc;
            ifid_q <= bubble_d;
        end else if (!stall) begin
            pc_q    <= npc;
            ifid_q  <= fetch_d;
            count_q <= count_q + 32'd1;
        end
    end

    assign pc          = pc_q;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_bd       = ifid_q.bd;
    assign id_exc      = ifid_q.exc;
    assign id_valid    = ifid_q.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a spec-level model checked every cycle,
// plus literal expectations from the test plan.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] npc;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_in_id = 1'b0;
    logic [31:0] im_rdata;
    logic [31:0] pc, id_instr, id_pc, fetch_count;
    logic        id_bd, id_valid;
    logic [4:0]  id_exc;

    int checks = 0;
    int failures = 0;

    // npc source: 0 = pc+4, 1 = fixed value, 2 = pc (termination)
    int          npc_mode = 0;
    logic [31:0] npc_fixed = 32'h0;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .npc(npc), .stall(stall), .flush(flush),
        .branch_in_id(branch_in_id), .im_rdata(im_rdata), .pc(pc),
        .id_instr(id_instr), .id_pc(id_pc), .id_bd(id_bd), .id_exc(id_exc),
        .id_valid(id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0001;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) &&
               ((a >= 32'h3000 && a <= 32'h6FFF) || (a >= 32'h4180 && a <= 32'h4FFF));
    endfunction

    assign im_rdata = mem(pc);
    assign npc = (npc_mode == 1) ? npc_fixed : (npc_mode == 2) ? pc : pc + 32'd4;

    // Reference model: architectural state written straight from the rules.
    logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
    logic        m_bd, m_valid;
    logic [4:0]  m_exc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h3000; m_instr = 0; m_idpc = 0; m_exc = 0; m_cnt = 0;
            m_bd = 0; m_valid = 0;
        end else if (flush) begin
            m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_idpc = npc;
            m_pc = npc;
        end else if (!stall) begin
            m_instr = addr_ok(m_pc) ? mem(m_pc) : 32'h0;
            m_exc   = addr_ok(m_pc) ? 5'd0 : 5'd4;
            m_idpc  = m_pc;
            m_bd    = branch_in_id;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
            m_pc    = npc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_pc", pc, m_pc);
        chk("m_id_instr", id_instr, m_instr);
        chk("m_id_pc", id_pc, m_idpc);
        chk("m_id_bd", {31'b0, id_bd}, {31'b0, m_bd});
        chk("m_id_exc", {27'b0, id_exc}, {27'b0, m_exc});
        chk("m_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        chk("m_fetch_count", fetch_count, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] saved_cnt, saved_pc;

    initial begin
        repeat (2) step();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        reset = 1'b0;

        // sequential fetch
        step();
        chk("seq_id_pc", id_pc, 32'h3000);
        chk("seq_id_instr", id_instr, 32'h2408_0001);
        chk("seq_id_valid", {31'b0, id_valid}, 32'h1);
        chk("seq_pc", pc, 32'h3004);
        chk("seq_count", fetch_count, 32'd1);
        step();
        chk("seq2_pc", pc, 32'h3008);

        // stall 3 edges
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_pc", pc, 32'h3008);
            chk("stall_id_pc", id_pc, 32'h3004);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        chk("unstall_id_pc", id_pc, 32'h3008);
        chk("unstall_count", fetch_count, 32'd3);

        // delay slot
        branch_in_id = 1'b1;
        step();
        chk("bd_set", {31'b0, id_bd}, 32'h1);
        chk("bd_id_pc", id_pc, 32'h300C);
        branch_in_id = 1'b0;
        step();
        chk("bd_clr", {31'b0, id_bd}, 32'h0);

        // misaligned fetch
        npc_mode = 1; npc_fixed = 32'h3002;
        step();
        chk("mis_pc", pc, 32'h3002);
        npc_fixed = 32'h3008;
        step();
        chk("mis_exc", {27'b0, id_exc}, 32'd4);
        chk("mis_instr", id_instr, 32'h0);
        chk("mis_valid", {31'b0, id_valid}, 32'h1);
        chk("mis_id_pc", id_pc, 32'h3002);

        // out-of-range fetch
        npc_fixed = 32'h0000_8000;
        step();
        npc_fixed = 32'h3000;
        step();
        chk("oor_exc", {27'b0, id_exc}, 32'd4);
        chk("oor_instr", id_instr, 32'h0);
        chk("oor_valid", {31'b0, id_valid}, 32'h1);
        chk("oor_id_pc", id_pc, 32'h8000);
        chk("oor_pc", pc, 32'h3000);

        // kernel-region fetch is legal
        npc_fixed = 32'h4FFC;
        step();
        npc_mode = 0;
        step();
        chk("kern_exc", {27'b0, id_exc}, 32'd0);
        chk("kern_instr", id_instr, 32'h4FFC ^ 32'hA5A5_0000);

        // flush with stall
        saved_cnt = fetch_count;
        npc_mode = 1; npc_fixed = 32'h4180;
        flush = 1'b1; stall = 1'b1; branch_in_id = 1'b1;
        step();
        chk("fl_pc", pc, 32'h4180);
        chk("fl_valid", {31'b0, id_valid}, 32'h0);
        chk("fl_instr", id_instr, 32'h0);
        chk("fl_bd", {31'b0, id_bd}, 32'h0);
        chk("fl_id_pc", id_pc, 32'h4180);
        chk("fl_count", fetch_count, saved_cnt);
        flush = 1'b0; stall = 1'b0; branch_in_id = 1'b0; npc_mode = 0;
        step();
        chk("postfl_id_pc", id_pc, 32'h4180);
        chk("postfl_count", fetch_count, saved_cnt + 1);

        // asynchronous reset between edges
        npc_mode = 1; npc_fixed = 32'h3010;
        step();
        chk("pre_rst_pc", pc, 32'h3010);
        npc_mode = 0;
        #1 reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h3000);
        chk("arst_count", fetch_count, 32'h0);
        chk("arst_valid", {31'b0, id_valid}, 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_id_pc", id_pc, 32'h3000);
        chk("post_rst_count", fetch_count, 32'd1);

        // termination: npc == pc
        npc_mode = 2;
        saved_pc = pc;
        saved_cnt = fetch_count;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("term_pc", pc, saved_pc);
            chk("term_count", fetch_count, saved_cnt + i);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter register and IF/ID pipeline latch for the five-stage MIPS core. Each cycle it registers the next PC from the next-PC selector, checks the fetch address, and captures the instruction word returned by instruction memory, together with its PC, delay-slot flag and fetch-exception code, into the IF/ID latch for decode. It honours hazard stalls and CP0 flushes, and keeps a running count of fetched instructions.

## Interface
- TEXT_START, 32'h0000_3000: user text base; PC reset value.
- TEXT_END, 32'h0000_6FFF: last valid user text byte address.
- KTEXT_START, 32'h0000_4180: kernel handler base; valid fetch region.
- KTEXT_END, 32'h0000_4FFF: last valid kernel text byte address.
- EXC_ADEL, 5'd4: ExcCode written on a bad fetch address.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- npc  in  32  next PC from the next-PC selector.
- stall  in  1  hazard hold: freeze PC and IF/ID latch.
- flush  in  1  CP0 exception entry or ERET: invalidate IF/ID contents.
- branch_in_id  in  1  instruction currently in ID is a branch or jump.
- im_rdata  in  32  instruction memory read data for `pc`, same cycle.
- pc  out  32  current fetch address, driven to instruction memory.
- id_instr  out  32  latched instruction word.
- id_pc  out  32  latched PC of `id_instr`.
- id_bd  out  1  latched instruction sits in a branch delay slot.
- id_exc  out  5  latched fetch ExcCode; 0 means none.
- id_valid  out  1  IF/ID holds a real fetched instruction and not a bubble.
- fetch_count  out  32  number of instructions latched into IF/ID.

## Operation
- Fetch check (combinational, on `pc`):
  - The address is bad when `pc[1:0] != 0`.
  - The address is also bad when `pc` lies outside both [TEXT_START, TEXT_END] and [KTEXT_START, KTEXT_END].
- On a bad fetch address, the captured instruction is forced to 32'h0000_0000 (nop) and the captured exc is EXC_ADEL. `im_rdata` is ignored.
- Each edge is decided by priority, highest first:
  1. reset (asynchronous): `pc` = TEXT_START; `id_instr`, `id_pc`, `id_exc`, `fetch_count` = 0; `id_bd`, `id_valid` = 0.
  2. flush:
     - `pc` <= `npc`, even if `stall` is also asserted.
     - `id_instr` <= 0, `id_exc` <= 0, `id_bd` <= 0, `id_valid` <= 0.
     - `id_pc` <= `npc`, so a bubble carries the PC CP0 would report.
     - `fetch_count` is unchanged.
  3. stall: every register holds its value.
  4. normal:
     - `pc` <= `npc`.
     - `id_instr` <= checked instruction; `id_pc` <= `pc`; `id_exc` <= checked exc.
     - `id_bd` <= `branch_in_id`; `id_valid` <= 1.
     - `fetch_count` <= `fetch_count` + 1, wrapping modulo 2^32.
- Program termination: when the selector returns `npc == pc`, the unit refetches the same address every cycle. Each refetch counts as a fetch, and no special state is entered.
- A bad fetch does not stop the PC. The unit still loads `npc` and relies on a later flush from CP0.

## Timing
- PC-to-ID latency: 1 cycle. Fetch at cycle N appears on `id_*` after edge N+1.
- `pc` and all `id_*` outputs are registered, and none of them depend combinationally on inputs.
- `im_rdata` must be valid within the same cycle as `pc`, because memory is asynchronous-read.
- `branch_in_id` is sampled on the same edge that captures the delay-slot instruction.
- A stall that starts mid-sequence holds for as many cycles as it is asserted. The first unstalled edge resumes with the held `pc`.
- When flush and stall are asserted together, flush wins, and the stall is dropped for that cycle.
- Reset asserted mid-operation returns all outputs to their reset values immediately, without waiting for `clk`. The first post-reset edge fetches at TEXT_START.

## Test plan
- Reset, then sequential fetch:
  - Stimulus: release reset; drive `npc = pc + 4`; `im_rdata = 32'h2408_0001` at 0x3000.
  - Required: after edge 1, `id_pc = 0x3000`, `id_instr = 32'h2408_0001`, `id_valid = 1`, `pc = 0x3004`, `fetch_count = 1`.
- Stall for 3 cycles:
  - Stimulus: assert `stall` while `pc = 0x3008`.
  - Required: `pc`, all `id_*` and `fetch_count` frozen for 3 edges; the 4th edge latches `id_pc = 0x3008`.
- Delay slot:
  - Stimulus: `branch_in_id = 1` on the edge capturing `pc = 0x300C`.
  - Required: `id_bd = 1` and `id_pc = 0x300C`; the next edge with `branch_in_id = 0` gives `id_bd = 0`.
- Bad fetch addresses:
  - Stimulus: `npc = 0x3002`, then separately `npc = 0x0000_8000`.
  - Required in both cases: after the capture edge, `id_exc = 4`, `id_instr = 0`, `id_valid = 1`.
- Flush with stall:
  - Stimulus: `flush = 1`, `stall = 1`, `npc = 0x4180`.
  - Required: `pc = 0x4180`, `id_valid = 0`, `id_instr = 0`, `id_bd = 0`, `fetch_count` unchanged.
- Asynchronous reset and termination:
  - Stimulus: pulse `reset` between edges while `pc = 0x3010`; separately drive `npc == pc`.
  - Required on reset: `pc` reads 0x3000 before the next edge.
  - Required on termination: `pc` stays constant while `fetch_count` increments by 1 per edge.
